// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_e    : symbolic FSM states (IDLE, SUB, CORR, DONE)
//   ST_*       : the same states as plain 2-bit constants, used by the RTL state register
//   MODE_*     : encodings of the mode input
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    CORR = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SUB  = 2'd1;
  localparam logic [1:0] ST_CORR = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic MODE_TWOS = 1'b0;
  localparam logic MODE_ONES = 1'b1;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle between a controller and the serial subtractor.
//   start, mode, a, b      : controller -> subtractor
//   busy, done, y, borrow,
//   overflow, zero         : subtractor -> controller
//
// Handshake: start is a request that is only sampled while the unit is idle;
// the edge on which it is seen with the unit idle is the accepting edge and
// captures a, b and mode. busy is high from that edge until the result is
// complete; done then pulses for exactly one cycle with y and the flags valid.
// Those outputs hold until the next accepting edge. start while busy or in the
// done cycle is dropped, not queued.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             borrow;
  logic             overflow;
  logic             zero;

  modport master (
    output start, mode, a, b,
    input  busy, done, y, borrow, overflow, zero
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, y, borrow, overflow, zero
  );
endinterface

// File: rtl/serial_subtractor_full_sub_cell.sv
// One-bit full subtractor: o_d = i_a - i_b - i_bin, o_bout = borrow out.
//   i_a, i_b : operand bits
//   i_bin    : borrow in
//   o_d      : difference bit
//   o_bout   : borrow out
module full_sub_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);
  assign o_d    = i_a ^ i_b ^ i_bin;
  // Borrow when b exceeds a, or when they are equal and a borrow is pending.
  assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock, through a single shared
// full-subtractor cell. Mode 0 gives two's-complement A - B; mode 1 gives
// one's-complement A + ~B by running a second serial pass that subtracts the
// end-around borrow when the first pass borrowed.
//   clk, rst_n    : clock, asynchronous active-low reset
//   sub_if        : operand/result bundle (slave side)
//   o_dbg_state   : current FSM state (sub_pkg ST_* encoding)
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  sub_if,
  output logic [1:0]          o_dbg_state
);

  localparam int              CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_y;
  logic             r_mode;
  logic             r_bin;
  logic             r_borrow;
  logic             r_ovf;
  logic             r_zero;

  logic             w_cell_a;
  logic             w_cell_b;
  logic             w_d;
  logic             w_bout;
  logic             w_last;
  logic [WIDTH-1:0] w_y_next;

  // In CORR the cell decrements y: y bit as minuend, zero subtrahend, and the
  // borrow chain seeded with 1 does the "- 1".
  always_comb begin
    w_cell_a = r_a[0];
    w_cell_b = r_b[0];
    if (r_state == ST_CORR) begin
      w_cell_a = r_y[0];
      w_cell_b = 1'b0;
    end
  end

  full_sub_cell u_cell (
    .i_a    (w_cell_a),
    .i_b    (w_cell_b),
    .i_bin  (r_bin),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  // y fills from the top; after WIDTH shifts the first bit sits at bit 0.
  assign w_y_next = {w_d, r_y[WIDTH-1:1]};
  assign w_last   = (r_cnt == LAST);

  function automatic logic is_zero(input logic [WIDTH-1:0] v, input logic m);
    return (v == '0) || ((m == MODE_ONES) && (v == '1));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_y      <= '0;
      r_mode   <= 1'b0;
      r_bin    <= 1'b0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (sub_if.start) begin
            r_a      <= sub_if.a;
            r_b      <= sub_if.b;
            r_mode   <= sub_if.mode;
            r_cnt    <= '0;
            r_bin    <= 1'b0;
            r_y      <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_state  <= ST_SUB;
          end
        end
        ST_SUB: begin
          r_y   <= w_y_next;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_bin <= w_bout;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            // On the last bit the operand LSBs are the original MSBs.
            r_borrow <= w_bout;
            r_ovf    <= (r_a[0] ^ r_b[0]) & (w_d ^ r_a[0]);
            r_cnt    <= '0;
            if ((r_mode == MODE_ONES) && w_bout) begin
              r_bin   <= 1'b1;
              r_state <= ST_CORR;
            end else begin
              r_zero  <= is_zero(w_y_next, r_mode);
              r_state <= ST_DONE;
            end
          end
        end
        ST_CORR: begin
          r_y   <= w_y_next;
          r_bin <= w_bout;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_cnt   <= '0;
            r_zero  <= is_zero(w_y_next, r_mode);
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sub_if.busy     = (r_state == ST_SUB) || (r_state == ST_CORR);
  assign sub_if.done     = (r_state == ST_DONE);
  assign sub_if.y        = r_y;
  assign sub_if.borrow   = r_borrow;
  assign sub_if.overflow = r_ovf;
  assign sub_if.zero     = r_zero;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
  import sub_pkg::*;

  typedef struct packed {
    logic [15:0] y;
    logic        borrow;
    logic        ovf;
    logic        zero;
    logic        busy_acc;
    logic        busy_done;
    logic [7:0]  lat;
  } res_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] drv_a = '0;
  logic [15:0] drv_b = '0;
  logic        drv_mode = 1'b0;
  logic        start8 = 1'b0;
  logic        start4 = 1'b0;
  logic        start16 = 1'b0;
  int          sel = 8;

  logic [1:0] st8, st4, st16;

  serial_subtractor_if #(.WIDTH(8))  if8 ();
  serial_subtractor_if #(.WIDTH(4))  if4 ();
  serial_subtractor_if #(.WIDTH(16)) if16 ();

  assign if8.start  = start8;
  assign if8.mode   = drv_mode;
  assign if8.a      = drv_a[7:0];
  assign if8.b      = drv_b[7:0];
  assign if4.start  = start4;
  assign if4.mode   = drv_mode;
  assign if4.a      = drv_a[3:0];
  assign if4.b      = drv_b[3:0];
  assign if16.start = start16;
  assign if16.mode  = drv_mode;
  assign if16.a     = drv_a;
  assign if16.b     = drv_b;

  serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .sub_if(if8),  .o_dbg_state(st8));
  serial_subtractor #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .sub_if(if4),  .o_dbg_state(st4));
  serial_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .sub_if(if16), .o_dbg_state(st16));

  // Selected-DUT view used by the driver.
  logic        cur_done, cur_busy, cur_borrow, cur_ovf, cur_zero;
  logic [15:0] cur_y;
  always_comb begin
    cur_done = if8.done; cur_busy = if8.busy; cur_borrow = if8.borrow;
    cur_ovf = if8.overflow; cur_zero = if8.zero; cur_y = {8'h00, if8.y};
    case (sel)
      4: begin
        cur_done = if4.done; cur_busy = if4.busy; cur_borrow = if4.borrow;
        cur_ovf = if4.overflow; cur_zero = if4.zero; cur_y = {12'h000, if4.y};
      end
      16: begin
        cur_done = if16.done; cur_busy = if16.busy; cur_borrow = if16.borrow;
        cur_ovf = if16.overflow; cur_zero = if16.zero; cur_y = if16.y;
      end
      default: ;
    endcase
  end

  int n_vec = 0;
  int n_fail = 0;
  res_t exp_q[$];

  // ---------------- reference model ----------------
  // Plain integer arithmetic on the mathematical definitions.
  function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic m);
    res_t r;
    int mask, ua, ub, sa, sb, sd, d;
    mask = (1 << w) - 1;
    ua = int'(a) & mask;
    ub = int'(b) & mask;
    sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    sd = sa - sb;
    r = '0;
    r.borrow = (ua < ub);
    r.ovf = (sd > (1 << (w - 1)) - 1) || (sd < -(1 << (w - 1)));
    d = (ua - ub) & mask;
    if (m && r.borrow) d = (d - 1) & mask;
    r.y = 16'(d);
    r.zero = (d == 0) || (m && (d == mask));
    r.lat = 8'((m && r.borrow) ? 2 * w : w);
    r.busy_acc = 1'b1;
    r.busy_done = 1'b0;
    return r;
  endfunction

  function automatic string fmt(input res_t r);
    return $sformatf("y=%h borrow=%b ovf=%b zero=%b lat=%0d busy_acc=%b busy_done=%b",
                     r.y, r.borrow, r.ovf, r.zero, r.lat, r.busy_acc, r.busy_done);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_start(input int w, input logic v);
    case (w)
      4:  start4 = v;
      16: start16 = v;
      default: start8 = v;
    endcase
  endtask

  // Called #1 after an edge with the selected DUT idle; returns what it saw.
  task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                        input logic m, output res_t obs);
    int lat;
    sel = w;
    drv_a = a; drv_b = b; drv_mode = m;
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    obs = '0;
    obs.busy_acc = cur_busy;
    // Operands must have been captured: scramble the inputs.
    drv_a = 16'($urandom); drv_b = 16'($urandom); drv_mode = 1'($urandom);
    lat = 0;
    while (cur_done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    obs.lat = 8'(lat);
    obs.y = cur_y;
    obs.borrow = cur_borrow;
    obs.ovf = cur_ovf;
    obs.zero = cur_zero;
    obs.busy_done = cur_busy;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({if8.busy, if8.done, if8.y, if8.borrow, if8.overflow, if8.zero, st8} !== '0) begin
      n_fail++;
      $display("FAIL reset_w8 busy=%b done=%b y=%h borrow=%b ovf=%b zero=%b state=%0d expected all 0",
               if8.busy, if8.done, if8.y, if8.borrow, if8.overflow, if8.zero, st8);
    end
    n_vec++;
    if ({if4.busy, if4.done, if4.y, if4.borrow, if4.overflow, if4.zero, st4} !== '0) begin
      n_fail++;
      $display("FAIL reset_w4 busy=%b done=%b y=%h state=%0d expected all 0",
               if4.busy, if4.done, if4.y, st4);
    end
    n_vec++;
    if ({if16.busy, if16.done, if16.y, if16.borrow, if16.overflow, if16.zero, st16} !== '0) begin
      n_fail++;
      $display("FAIL reset_w16 busy=%b done=%b y=%h state=%0d expected all 0",
               if16.busy, if16.done, if16.y, st16);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (st8 !== ST_IDLE || if8.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release state=%0d done=%b expected state=%0d done=0", st8, if8.done, ST_IDLE);
    end
  endtask

  task automatic test_directed;
    logic [15:0] ta [8] = '{16'h05, 16'h03, 16'h03, 16'h80, 16'h7F, 16'h05, 16'h00, 16'h00};
    logic [15:0] tb [8] = '{16'h03, 16'h05, 16'h05, 16'h01, 16'hFF, 16'h05, 16'h00, 16'hFF};
    logic        tm [8] = '{MODE_TWOS, MODE_TWOS, MODE_ONES, MODE_TWOS, MODE_TWOS,
                            MODE_ONES, MODE_ONES, MODE_ONES};
    logic [15:0] ty [8] = '{16'h02, 16'hFE, 16'hFD, 16'h7F, 16'h80, 16'h00, 16'h00, 16'h00};
    res_t obs, exp;
    for (int i = 0; i < 8; i++) begin
      run_op(8, ta[i], tb[i], tm[i], obs);
      exp = model(8, ta[i], tb[i], tm[i]);
      n_vec++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL directed[%0d] got %s want %s", i, fmt(obs), fmt(exp));
      end
      n_vec++;
      if (obs.y !== ty[i]) begin
        n_fail++;
        $display("FAIL directed_y[%0d] got %h want %h", i, obs.y, ty[i]);
      end
    end
  endtask

  task automatic test_start_held;
    int got[$];
    int w = 8;
    sel = 8;
    drv_a = 16'h005A; drv_b = 16'h0033; drv_mode = MODE_TWOS;
    start8 = 1'b1;
    @(posedge clk); #1;
    for (int n = 1; n <= 3 * (w + 2); n++) begin
      @(posedge clk); #1;
      if (if8.done === 1'b1) got.push_back(n);
      if (n == w + 1) begin
        n_vec++;
        if ({if8.busy, if8.done, if8.y} !== {1'b0, 1'b0, 8'h27}) begin
          n_fail++;
          $display("FAIL hold_after_done busy=%b done=%b y=%h want busy=0 done=0 y=27",
                   if8.busy, if8.done, if8.y);
        end
      end
    end
    start8 = 1'b0;
    n_vec++;
    if (got.size() != 3) begin
      n_fail++;
      $display("FAIL start_held_count got %0d done pulses want 3", got.size());
    end else begin
      n_vec++;
      if (got[0] != w || got[1] != 2 * w + 2 || got[2] != 3 * w + 4) begin
        n_fail++;
        $display("FAIL start_held_spacing got %0d,%0d,%0d want %0d,%0d,%0d",
                 got[0], got[1], got[2], w, 2 * w + 2, 3 * w + 4);
      end
    end
    repeat (2 * w + 4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    res_t obs, exp;
    logic [15:0] ra, rb;
    sel = 8;
    drv_a = 16'h00FF; drv_b = 16'h0000; drv_mode = MODE_TWOS;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({if8.busy, if8.done, if8.y, if8.borrow, if8.overflow, if8.zero, st8} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid busy=%b done=%b y=%h state=%0d expected all 0",
               if8.busy, if8.done, if8.y, st8);
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 1) rst_n = 1'b1;
      if (if8.done === 1'b1) dones++;
    end
    n_vec++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done got %0d done pulses want 0", dones);
    end
    ra = 16'($urandom); rb = 16'($urandom);
    run_op(8, ra, rb, MODE_ONES, obs);
    exp = model(8, ra, rb, MODE_ONES);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_mid_fresh got %s want %s", fmt(obs), fmt(exp));
    end
  endtask

  task automatic test_random;
    int widths [3] = '{8, 4, 16};
    res_t obs, exp;
    logic [15:0] ra, rb;
    logic rm;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 25; i++) begin
        ra = 16'($urandom);
        rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
        rm = 1'($urandom_range(0, 1));
        exp_q.push_back(model(widths[k], ra, rb, rm));
        run_op(widths[k], ra, rb, rm, obs);
        exp = exp_q.pop_front();
        n_vec++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL random_w%0d[%0d] a=%h b=%h mode=%b got %s want %s",
                   widths[k], i, ra, rb, rm, fmt(obs), fmt(exp));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_held();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised, bit-serial subtract unit that computes A − B over WIDTH operands in either two's-complement or one's-complement mode, one bit per clock, LSB first. It replaces the fixed-width combinational subtract paths with a single shared full-subtractor cell, a start/busy/done handshake and status flags. It sits behind the switch/LED top level or any controller that issues operands and waits for `done`.

## Interface
- `WIDTH`, 8, operand and result width in bits (≥2)
- `clk`  in  1  system clock, rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only in IDLE
- `mode`  in  1  0 = two's complement, 1 = one's complement (end-around borrow)
- `a`  in  WIDTH  minuend, captured on the accepting edge
- `b`  in  WIDTH  subtrahend, captured on the accepting edge
- `busy`  out  1  high in SUB and CORR
- `done`  out  1  one-cycle pulse, result valid
- `y`  out  WIDTH  difference, held until next accepted start
- `borrow`  out  1  unsigned borrow-out of first pass (a < b)
- `overflow`  out  1  signed overflow of first pass
- `zero`  out  1  y all-zeros; in mode 1 also set for all-ones (negative zero)

One clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, SUB, CORR, DONE.
- IDLE: `start`=1 → latch a, b, mode; clear bit counter and borrow chain; clear y, flags → SUB.
- SUB: per cycle, full_sub_cell on (a[i], b[i], bin) → y[i], bout; i increments. After bit WIDTH−1: record borrow = final bout; overflow = (a[MSB]≠b[MSB]) & (y[MSB]≠a[MSB]).
- SUB exit: mode 1 and borrow=1 → CORR (counter reset, bin=1, b operand treated as zero); otherwise → DONE.
- CORR: decrement y by 1 serially, WIDTH cycles (y = D − 1, i.e. A + ~B). borrow/overflow not updated.
- DONE: `done`=1 one cycle, compute `zero` → IDLE.
- Arithmetic: two's y = (A − B) mod 2^WIDTH; one's y = (A − B) mod 2^WIDTH − borrow.
- `start` outside IDLE ignored (no queueing). Inputs a/b/mode may change freely after acceptance.

## Timing
- Reset (async assert): state IDLE; busy=0, done=0, y=0, borrow=0, overflow=0, zero=0. Reset mid-operation aborts; no done pulse.
- Accepting edge = edge k (IDLE, start=1). busy high from k.
- No correction: bits processed on edges k+1…k+WIDTH; done high between edges k+WIDTH and k+WIDTH+1.
- With correction (mode 1, borrow): CORR on edges k+WIDTH+1…k+2·WIDTH; done high for one cycle after edge k+2·WIDTH.
- busy low in the DONE cycle; start asserted during DONE is ignored, accepted from next IDLE cycle. Minimum issue interval WIDTH+2 cycles.
- y, borrow, overflow, zero stable from done cycle until next accepting edge.

## Structure
- Package `sub_pkg`: state enum (IDLE, SUB, CORR, DONE), `MODE_TWOS`=0, `MODE_ONES`=1.
- Sub-module `full_sub_cell`: combinational (a, b, bin) → (d, bout); single instance shared by SUB and CORR.
- Counter width $clog2(WIDTH); shift registers for a, b, y.

## Test plan
- WIDTH=8, mode 0, a=5, b=3 → y=8'h02, borrow=0, overflow=0, zero=0, done 8 cycles after accept.
- mode 0, a=3, b=5 → y=8'hFE, borrow=1, overflow=0, done at 8 cycles; mode 1 same operands → y=8'hFD, borrow=1, done at 16 cycles.
- mode 0, a=8'h80, b=8'h01 → y=8'h7F, overflow=1, borrow=0; a=8'h7F, b=8'hFF → y=8'h80, overflow=1.
- mode 1, a=5, b=5 → y=8'h00, zero=1, no CORR (8 cycles); mode 1, a=0, b=0 → y=0, zero=1.
- Start pulsed on every cycle of an operation → only first accepted, exactly one done per WIDTH+2 cycles; y unchanged until next accept.
- rst_n low at cycle 4 of SUB → outputs zero immediately, no done; fresh start after release gives correct result; repeat with WIDTH=4 and WIDTH=16 random operands against a reference model.
